// File: rtl/shift_issue_pkg.sv
// shift_pkg: opcodes, shifter control bundle and micro-op decode for the shift issue stage
package shift_pkg;

    localparam int SHOP_W = 3;
    localparam int SH_W   = 5;

    typedef enum logic [SHOP_W-1:0] {
        SHOP_SLL,
        SHOP_SRL,
        SHOP_SRA,
        SHOP_ROR,
        SHOP_ROL,
        SHOP_BFXU,
        SHOP_BFXS,
        SHOP_RSV
    } shop_e;

    typedef struct packed {
        logic [31:0]     op;
        logic [SH_W-1:0] sh;
        logic [SH_W-1:0] maskbits;
        logic            left;
        logic            sx;
    } shift_ctl_t;

    // Bitfield extract rotates the field down to bit 0 and keeps wid_m1+1 bits.
    function automatic shift_ctl_t shift_decode(
        input shop_e           op,
        input logic [31:0]     rs1,
        input logic [SH_W-1:0] amt,
        input logic [SH_W-1:0] wid_m1
    );
        shift_ctl_t c;
        c.op       = rs1;
        c.sh       = (op == SHOP_RSV) ? '0 : amt;
        c.maskbits = (op inside {SHOP_SLL, SHOP_SRL, SHOP_SRA}) ? amt :
                     (op inside {SHOP_BFXU, SHOP_BFXS}) ? ~wid_m1 : '0;
        c.left     = op inside {SHOP_SLL, SHOP_ROL};
        c.sx       = op inside {SHOP_SRA, SHOP_BFXS};
        return c;
    endfunction

endpackage

// File: rtl/shift_issue_skid_buf.sv
// skid_buf: 2-entry valid/ready register slice with a registered in_ready and synchronous flush
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         acc;
    logic         load;

    assign in_ready = !skid_valid;
    assign acc      = in_valid && !skid_valid;
    assign load     = !out_valid || out_ready;

    // The skid entry only fills while the output register is held, so it always holds the younger op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (load) begin
            out_valid  <= skid_valid || acc;
            skid_valid <= 1'b0;
            if (skid_valid)
                out_data <= skid_data;
            else if (acc)
                out_data <= in_data;
        end else if (acc) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/shift_issue.sv
// shift_issue: decodes shift/bitfield micro-ops into barrel shifter controls behind a skid buffer
module shift_issue
    import shift_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [4:0]       in_imm5,
    input  logic [4:0]       in_wid_m1,
    input  logic             in_amt_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_op,
    output logic [4:0]       out_sh,
    output logic [4:0]       out_maskbits,
    output logic             out_left,
    output logic             out_sx,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             out_fld_wrap
);

    localparam int PW = $bits(shift_ctl_t) + TAG_W + 2;

    shop_e           op;
    logic [SH_W-1:0] amt;
    shift_ctl_t      ctl;
    shift_ctl_t      ctl_q;
    logic            illegal;
    logic            fld_wrap;
    logic [PW-1:0]   pay_in;
    logic [PW-1:0]   pay_out;
    logic [26:0]     unused_rs2;

    assign unused_rs2 = in_rs2[31:5];
    assign op         = shop_e'(in_op);
    assign amt        = in_amt_sel ? in_rs2[SH_W-1:0] : in_imm5;
    assign ctl        = shift_decode(op, in_rs1, amt, in_wid_m1);
    assign illegal    = op == SHOP_RSV;
    // Informational only: the shifter still returns the rotated field.
    assign fld_wrap   = (op inside {SHOP_BFXU, SHOP_BFXS}) && (({1'b0, amt} + {1'b0, in_wid_m1}) > 6'd31);
    assign pay_in     = {ctl, in_tag, illegal, fld_wrap};

    skid_buf #(.W(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out)
    );

    assign {ctl_q, out_tag, out_illegal, out_fld_wrap} = pay_out;
    assign out_op       = ctl_q.op;
    assign out_sh       = ctl_q.sh;
    assign out_maskbits = ctl_q.maskbits;
    assign out_left     = ctl_q.left;
    assign out_sx       = ctl_q.sx;

endmodule

// File: tb/tb_shift_issue.sv
// tb_shift_issue: directed and random checks of shift_issue against a queue-based reference model
module tb_shift_issue;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = '0;
    logic [31:0]      in_rs1 = '0;
    logic [31:0]      in_rs2 = '0;
    logic [4:0]       in_imm5 = '0;
    logic [4:0]       in_wid_m1 = '0;
    logic             in_amt_sel = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_op;
    logic [4:0]       out_sh;
    logic [4:0]       out_maskbits;
    logic             out_left;
    logic             out_sx;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic             out_fld_wrap;

    int n_chk = 0;
    int n_pass = 0;
    logic [50:0] q[$];

    always #5 clk = ~clk;

    shift_issue #(.TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm5      (in_imm5),
        .in_wid_m1    (in_wid_m1),
        .in_amt_sel   (in_amt_sel),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op       (out_op),
        .out_sh       (out_sh),
        .out_maskbits (out_maskbits),
        .out_left     (out_left),
        .out_sx       (out_sx),
        .out_tag      (out_tag),
        .out_illegal  (out_illegal),
        .out_fld_wrap (out_fld_wrap)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Expected output bundle built from the opcode table with plain arithmetic.
    function automatic logic [50:0] ref_pack(input int op, input logic [31:0] rs1, input logic [31:0] rs2,
                                             input int imm, input int wid, input logic sel, input int tag);
        int a, sh, mb;
        logic left, sx, ill, wrap;
        a    = sel ? int'(rs2 % 32) : imm;
        sh   = (op == 7) ? 0 : a;
        mb   = (op <= 2) ? a : (op == 5 || op == 6) ? 31 - wid : 0;
        left = op == 0 || op == 4;
        sx   = op == 2 || op == 6;
        ill  = op == 7;
        wrap = (op == 5 || op == 6) && (a + wid > 31);
        return {rs1, 5'(sh), 5'(mb), left, sx, 5'(tag), ill, wrap};
    endfunction

    task automatic compare_all();
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0)
            check("payload", 64'({out_op, out_sh, out_maskbits, out_left, out_sx, out_tag, out_illegal, out_fld_wrap}),
                  64'(q[0]));
    endtask

    // Called at a negedge: drive one cycle of inputs, advance the model, then check after the edge.
    task automatic cyc(input logic v, input int op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input int imm, input int wid, input logic sel, input int tag,
                       input logic ordy, input logic fl);
        logic m_rdy, m_val;
        in_valid   = v;
        in_op      = 3'(op);
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_imm5    = 5'(imm);
        in_wid_m1  = 5'(wid);
        in_amt_sel = sel;
        in_tag     = TAG_W'(tag);
        out_ready  = ordy;
        flush      = fl;
        m_rdy = q.size() < 2;
        m_val = q.size() > 0;
        if (fl) begin
            q.delete();
        end else begin
            if (m_val && ordy) void'(q.pop_front());
            if (v && m_rdy) q.push_back(ref_pack(op, rs1, rs2, imm, wid, sel, tag));
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 0, 32'h0, 32'h0, 0, 0, 1'b0, 0, ordy, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_payload", 64'({out_op, out_sh, out_maskbits, out_left, out_sx, out_tag, out_illegal, out_fld_wrap}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        cyc(1'b1, 0, 32'h0000_00F1, 32'h0, 4, 0, 1'b0, 1, 1'b1, 1'b0);
        check("sll_ctl", 64'({out_left, out_sh, out_maskbits, out_sx}), 64'({1'b1, 5'd4, 5'd4, 1'b0}));
        cyc(1'b1, 6, 32'h0000_0A50, 32'h0, 4, 7, 1'b0, 2, 1'b1, 1'b0);
        check("bfxs_ctl", 64'({out_sh, out_maskbits, out_sx, out_fld_wrap}), 64'({5'd4, 5'd24, 1'b1, 1'b0}));
        cyc(1'b1, 6, 32'h0000_0A50, 32'h0, 28, 7, 1'b0, 3, 1'b1, 1'b0);
        check("bfxs_wrap", 64'(out_fld_wrap), 64'd1);
        cyc(1'b1, 2, 32'h8000_0000, 32'h0000_0FFF, 0, 0, 1'b1, 4, 1'b1, 1'b0);
        check("sra_ctl", 64'({out_sh, out_maskbits, out_sx}), 64'({5'd31, 5'd31, 1'b1}));
        cyc(1'b1, 7, 32'h1234_5678, 32'h0, 9, 3, 1'b0, 21, 1'b1, 1'b0);
        check("ill_ctl", 64'({out_illegal, out_sh, out_maskbits, out_left, out_sx, out_tag}), 64'({1'b1, 12'd0, 5'd21}));
        idle(1'b1);

        // Backpressure: A to output, B to skid, C held until space frees.
        cyc(1'b1, 1, 32'hAAAA_0001, 32'h0, 1, 0, 1'b0, 10, 1'b0, 1'b0);
        cyc(1'b1, 1, 32'hBBBB_0002, 32'h0, 2, 0, 1'b0, 11, 1'b0, 1'b0);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        cyc(1'b1, 1, 32'hCCCC_0003, 32'h0, 3, 0, 1'b0, 12, 1'b0, 1'b0);
        check("bp_hold_a", 64'(out_tag), 64'd10);
        cyc(1'b1, 1, 32'hCCCC_0003, 32'h0, 3, 0, 1'b0, 12, 1'b1, 1'b0);
        check("bp_b", 64'(out_tag), 64'd11);
        cyc(1'b1, 1, 32'hCCCC_0003, 32'h0, 3, 0, 1'b0, 12, 1'b1, 1'b0);
        check("bp_c", 64'(out_tag), 64'd12);
        idle(1'b1);

        // Flush with skid full and a third op offered.
        cyc(1'b1, 3, 32'h1111_1111, 32'h0, 5, 0, 1'b0, 1, 1'b0, 1'b0);
        cyc(1'b1, 4, 32'h2222_2222, 32'h0, 6, 0, 1'b0, 2, 1'b0, 1'b0);
        cyc(1'b1, 5, 32'h3333_3333, 32'h0, 7, 2, 1'b0, 3, 1'b0, 1'b1);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        idle(1'b1);
        idle(1'b1);

        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                #2 rst_n = 1'b0;
                #1;
                check("async_rst_valid", 64'(out_valid), 64'd0);
                q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check("post_rst_ready", 64'(in_ready), 64'd1);
            end
            cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), $urandom, $urandom,
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'($urandom), int'($urandom_range(0, 31)),
                $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end
        idle(1'b1);
        idle(1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
